// File: rtl/state_sequencer.sv
// Run sequencer: steps an externally incremented 3-bit state from 0 up to a latched limit,
// with pause/clear control, a completed-run counter and an incrementer integrity flag.
module state_sequencer #(
    parameter int unsigned LAPS_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pause,
    input  logic              clear,
    input  logic [2:0]        limit,
    input  logic [2:0]        qnext,
    output logic [2:0]        q,
    output logic              busy,
    output logic              done,
    output logic              wrap,
    output logic [LAPS_W-1:0] laps,
    output logic              err
);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

    state_e     state_q;
    logic [2:0] lim_q;
    logic       start_q;
    logic       rise;

    assign rise = start & ~start_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            q       <= 3'd0;
            lim_q   <= 3'd0;
            start_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wrap    <= 1'b0;
            laps    <= '0;
            err     <= 1'b0;
        end else begin
            start_q <= start;
            done    <= 1'b0;
            wrap    <= 1'b0;
            if (clear) begin
                state_q <= StIdle;
                q       <= 3'd0;
                busy    <= 1'b0;
                err     <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (rise) begin
                            state_q <= StRun;
                            q       <= 3'd0;
                            lim_q   <= limit;
                            busy    <= 1'b1;
                        end
                    end
                    StRun: begin
                        if (pause) begin
                            state_q <= StPause;
                        end else if (q == lim_q) begin
                            state_q <= StDone;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            if (laps != '1) begin
                                laps <= laps + 1'b1;
                            end
                        end else begin
                            // The incrementer's value is loaded even when it is wrong.
                            q <= qnext;
                            if (qnext != q + 3'd1) begin
                                err <= 1'b1;
                            end
                            if (q == 3'd7 && qnext == 3'd0) begin
                                wrap <= 1'b1;
                            end
                        end
                    end
                    StPause: begin
                        if (!pause) begin
                            state_q <= StRun;
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_state_sequencer.sv
// Directed bench for state_sequencer with a behavioural incrementer that can inject a fault.
module tb_state_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       pause;
    logic       clear;
    logic [2:0] limit;
    logic [2:0] qnext;
    logic [2:0] q;
    logic       busy;
    logic       done;
    logic       wrap;
    logic [3:0] laps;
    logic       err;
    logic       fault;

    int n_checks = 0;
    int n_errors = 0;

    state_sequencer #(.LAPS_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .pause (pause),
        .clear (clear),
        .limit (limit),
        .qnext (qnext),
        .q     (q),
        .busy  (busy),
        .done  (done),
        .wrap  (wrap),
        .laps  (laps),
        .err   (err)
    );

    always #5 clk = ~clk;

    // Faulty incrementer skips a state (3 -> 5) when fault is set.
    assign qnext = (fault && q == 3'd3) ? 3'd5 : q + 3'd1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [2:0] lim);
        start = 1'b1;
        limit = lim;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        clear = 1'b0;
        limit = 3'd0;
        fault = 1'b0;
        #3;
        check("rst_q", q, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wrap", wrap, 0);
        check("rst_laps", laps, 0);
        check("rst_err", err, 0);
        step();
        step();
        rst = 1'b1;
        step();

        // limit 5, ideal incrementer
        launch(3'd5);
        check("t1_q0", q, 0);
        check("t1_busy0", busy, 1);
        for (int i = 1; i <= 5; i++) begin
            step();
            check("t1_q", q, i);
            check("t1_nodone", done, 0);
        end
        step();
        check("t1_done", done, 1);
        check("t1_busy_done", busy, 0);
        check("t1_q_hold", q, 5);
        check("t1_laps", laps, 1);
        step();
        check("t1_done_end", done, 0);
        check("t1_busy_idle", busy, 0);

        // limit 6, pause for 3 cycles at q=2
        launch(3'd6);
        step();
        step();
        check("t2_q2", q, 2);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_hold", q, 2);
            check("t2_busy", busy, 1);
        end
        pause = 1'b0;
        step();
        check("t2_resume", q, 2);
        step();
        check("t2_q3", q, 3);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_nodone", done, 0);
        end
        check("t2_q6", q, 6);
        step();
        check("t2_done", done, 1);
        check("t2_laps", laps, 2);
        step();

        // limit 0: zero-length run
        launch(3'd0);
        check("t3_busy", busy, 1);
        check("t3_q", q, 0);
        step();
        check("t3_done", done, 1);
        check("t3_busy_off", busy, 0);
        check("t3_q0", q, 0);
        check("t3_laps", laps, 3);
        step();

        // faulty incrementer, limit 7
        fault = 1'b1;
        launch(3'd7);
        step();
        step();
        step();
        check("t4_q3", q, 3);
        check("t4_err_pre", err, 0);
        step();
        check("t4_q5", q, 5);
        check("t4_err", err, 1);
        step();
        step();
        check("t4_q7", q, 7);
        step();
        check("t4_done", done, 1);
        check("t4_err_done", err, 1);
        check("t4_laps", laps, 4);
        step();
        check("t4_err_idle", err, 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("t4_err_clr", err, 0);

        // fault skips over limit 4, so q reaches 7 and wraps to 0
        launch(3'd4);
        for (int i = 0; i < 6; i++) step();
        check("t5_q7", q, 7);
        check("t5_nowrap", wrap, 0);
        step();
        check("t5_q0", q, 0);
        check("t5_wrap", wrap, 1);
        step();
        check("t5_wrap_off", wrap, 0);
        check("t5_q1", q, 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        fault = 1'b0;
        check("t5_clr_busy", busy, 0);
        check("t5_laps", laps, 4);

        // asynchronous reset mid-run at q=4
        launch(3'd7);
        for (int i = 0; i < 4; i++) step();
        check("t6_q4", q, 4);
        #2;
        rst = 1'b0;
        #1;
        check("t6_async_q", q, 0);
        check("t6_async_busy", busy, 0);
        check("t6_async_laps", laps, 0);
        step();
        check("t6_nodone", done, 0);
        rst = 1'b1;
        step();
        check("t6_idle", busy, 0);

        // 16+ runs saturate laps
        for (int i = 0; i < 17; i++) begin
            launch(3'd0);
            step();
            step();
            if (i == 14) check("t7_laps15", laps, 15);
        end
        check("t7_sat", laps, 15);

        // clear and pause together in RUN
        launch(3'd5);
        step();
        step();
        clear = 1'b1;
        pause = 1'b1;
        step();
        check("t8_q", q, 0);
        check("t8_busy", busy, 0);
        clear = 1'b0;
        pause = 1'b0;
        step();
        check("t8_idle", busy, 0);

        // start held high across a run: no second run
        start = 1'b1;
        limit = 3'd2;
        step();
        check("t9_busy", busy, 1);
        step();
        step();
        step();
        check("t9_done", done, 1);
        step();
        step();
        step();
        check("t9_norerun", busy, 0);

        // start held through reset gives one rise on the first edge
        rst = 1'b0;
        #2;
        rst = 1'b1;
        step();
        check("t10_rise", busy, 1);
        start = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("t10_clr", busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
